// File: rtl/posit_round_pkg.sv
// Shared definitions for the posit rounding pipeline.
// Holds the rounding-mode enum, the derived-width helpers used by the
// interface, top and lane, and the LFSR polynomial/step used for
// stochastic rounding.
package posit_round_pkg;

  typedef enum logic [1:0] {
    RND_RNE   = 2'd0,
    RND_RTZ   = 2'd1,
    RND_RAZ   = 2'd2,
    RND_STOCH = 2'd3
  } rnd_mode_e;

  // 16-bit Galois LFSR feedback mask.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int fracBits(input int width, input int es);
    return ((width - 3 - es) < 1) ? 1 : (width - 3 - es);
  endfunction

  function automatic int scaleBits(input int width, input int es);
    return $clog2(width) + es + 1;
  endfunction

  function automatic int maxScale(input int width, input int es);
    return (width - 2) << es;
  endfunction

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/posit_round_pipe_if.sv
// Streaming interface of the posit rounding pipeline.
// in_*  : unpacked posit lanes plus guard/trailing/sticky and a rounding mode,
//         valid/ready handshake (in_valid/in_ready).
// out_* : rounded lanes plus per-lane inexact flag, valid/ready handshake
//         (out_valid/out_ready).
// master: the producer/consumer side (datapath feeding in, encoder taking out).
// slave : the rounding pipeline itself.
interface posit_round_pipe_if import posit_round_pkg::*; #(
  parameter int WIDTH         = 8,
  parameter int ES            = 1,
  parameter int LANES         = 1,
  parameter int TRAILING_BITS = 2
);
  localparam int FRAC_BITS  = fracBits(WIDTH, ES);
  localparam int SCALE_BITS = scaleBits(WIDTH, ES);

  logic                             in_valid;
  logic                             in_ready;
  logic [1:0]                       in_mode;
  logic [LANES-1:0]                 in_sign;
  logic [LANES-1:0]                 in_isZero;
  logic [LANES-1:0]                 in_isInf;
  logic [LANES*SCALE_BITS-1:0]      in_scale;
  logic [LANES*FRAC_BITS-1:0]       in_fraction;
  logic [LANES*TRAILING_BITS-1:0]   in_trailing;
  logic [LANES-1:0]                 in_sticky;

  logic                             out_valid;
  logic                             out_ready;
  logic [LANES-1:0]                 out_sign;
  logic [LANES-1:0]                 out_isZero;
  logic [LANES-1:0]                 out_isInf;
  logic [LANES*SCALE_BITS-1:0]      out_scale;
  logic [LANES*FRAC_BITS-1:0]       out_fraction;
  logic [LANES-1:0]                 out_inexact;

  modport master (
    output in_valid, in_mode, in_sign, in_isZero, in_isInf, in_scale,
           in_fraction, in_trailing, in_sticky, out_ready,
    input  in_ready, out_valid, out_sign, out_isZero, out_isInf, out_scale,
           out_fraction, out_inexact
  );

  modport slave (
    input  in_valid, in_mode, in_sign, in_isZero, in_isInf, in_scale,
           in_fraction, in_trailing, in_sticky, out_ready,
    output in_ready, out_valid, out_sign, out_isZero, out_isInf, out_scale,
           out_fraction, out_inexact
  );

endinterface

// File: rtl/posit_round_lane.sv
// Combinational round-up decision and fraction increment for one lane.
// Ports: mode, is_zero/is_inf flags, fraction, trailing (MSB = guard),
// sticky, rnd (low LFSR bits for stochastic mode) in; frac_inc, carry
// (fraction overflowed into the next scale), inexact out.
module posit_round_lane import posit_round_pkg::*; #(
  parameter int FB = 4,
  parameter int TB = 2
) (
  input  rnd_mode_e       mode,
  input  logic            is_zero,
  input  logic            is_inf,
  input  logic [FB-1:0]   fraction,
  input  logic [TB-1:0]   trailing,
  input  logic            sticky,
  input  logic [TB:0]     rnd,
  output logic [FB-1:0]   frac_inc,
  output logic            carry,
  output logic            inexact
);

  logic [TB:0]   tail;
  logic          guard;
  logic          rest;
  logic          any_tail;
  logic          special;
  logic [TB+1:0] stoch_sum;
  logic          up_raw;
  logic          up;

  // Sticky appended below the trailing bits: everything discarded, MSB first.
  assign tail      = {trailing, sticky};
  assign guard     = tail[TB];
  assign rest      = |tail[TB-1:0];
  assign any_tail  = |tail;
  assign special   = is_zero | is_inf;
  assign stoch_sum = {1'b0, tail} + {1'b0, rnd};

  always_comb begin
    up_raw = 1'b0;
    unique case (mode)
      RND_RNE:   up_raw = guard & (rest | fraction[0]);
      RND_RTZ:   up_raw = 1'b0;
      RND_RAZ:   up_raw = any_tail;
      RND_STOCH: up_raw = stoch_sum[TB+1];
      default:   up_raw = 1'b0;
    endcase
  end

  assign up      = up_raw & ~special;
  assign inexact = any_tail & ~special;
  assign {carry, frac_inc} = {1'b0, fraction} + {{FB{1'b0}}, up};

endmodule

// File: rtl/posit_round_pipe.sv
// Two-stage, multi-lane posit rounding pipeline.
// Ports: clock, reset (synchronous, active high), bus (slave side of
// posit_round_pipe_if carrying the input and output valid/ready streams).
// S1 registers the per-lane rounding decision and incremented fraction;
// S2 applies the fraction carry to the scale and saturates at maxpos.
// Each lane owns a Galois LFSR that steps once per accepted beat.
module posit_round_pipe import posit_round_pkg::*; #(
  parameter int          WIDTH         = 8,
  parameter int          ES            = 1,
  parameter int          LANES         = 1,
  parameter int          TRAILING_BITS = 2,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset,
  posit_round_pipe_if.slave bus
);

  localparam int FB = fracBits(WIDTH, ES);
  localparam int SB = scaleBits(WIDTH, ES);
  localparam int MS = maxScale(WIDTH, ES);
  localparam int TB = TRAILING_BITS;
  localparam logic [SB:0]   MAX_EXT = (SB+1)'(MS);
  localparam logic [SB-1:0] MAX_SC  = SB'(MS);

  rnd_mode_e          in_mode_e;
  logic               s2_adv;
  logic               accept;

  logic               s1_valid;
  logic [LANES-1:0]   s1_sign;
  logic [LANES-1:0]   s1_zero;
  logic [LANES-1:0]   s1_inf;
  logic [LANES-1:0]   s1_carry;
  logic [LANES-1:0]   s1_inexact;
  logic [LANES*SB-1:0] s1_scale;
  logic [LANES*FB-1:0] s1_frac;

  logic [15:0]        lfsr [LANES];

  logic [LANES*FB-1:0] frac_inc;
  logic [LANES-1:0]   carry;
  logic [LANES-1:0]   inexact;

  logic [SB:0]        sc_sum [LANES];
  logic [LANES-1:0]   sat;
  logic [LANES*SB-1:0] nxt_scale;
  logic [LANES*FB-1:0] nxt_frac;

  assign in_mode_e    = rnd_mode_e'(bus.in_mode);
  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    posit_round_lane #(
      .FB (FB),
      .TB (TB)
    ) u_lane (
      .mode     (in_mode_e),
      .is_zero  (bus.in_isZero[l]),
      .is_inf   (bus.in_isInf[l]),
      .fraction (bus.in_fraction[l*FB +: FB]),
      .trailing (bus.in_trailing[l*TB +: TB]),
      .sticky   (bus.in_sticky[l]),
      .rnd      (lfsr[l][TB:0]),
      .frac_inc (frac_inc[l*FB +: FB]),
      .carry    (carry[l]),
      .inexact  (inexact[l])
    );
  end

  // Scale is sign-extended by one bit so scale+1 cannot wrap before the
  // saturation compare.
  always_comb begin
    nxt_scale = '0;
    nxt_frac  = '0;
    sat       = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sc_sum[l] = {s1_scale[l*SB + SB - 1], s1_scale[l*SB +: SB]}
                + {{SB{1'b0}}, s1_carry[l]};
      sat[l] = !s1_zero[l] && !s1_inf[l] && ($signed(sc_sum[l]) > $signed(MAX_EXT));
      nxt_scale[l*SB +: SB] = sat[l] ? MAX_SC : sc_sum[l][SB-1:0];
      nxt_frac[l*FB +: FB]  = sat[l] ? '0 : s1_frac[l*FB +: FB];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid         <= 1'b0;
      s1_sign          <= '0;
      s1_zero          <= '0;
      s1_inf           <= '0;
      s1_carry         <= '0;
      s1_inexact       <= '0;
      s1_scale         <= '0;
      s1_frac          <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_sign     <= '0;
      bus.out_isZero   <= '0;
      bus.out_isInf    <= '0;
      bus.out_scale    <= '0;
      bus.out_fraction <= '0;
      bus.out_inexact  <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        lfsr[l] <= SEED ^ 16'(l);
      end
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
      end
      if (accept) begin
        s1_sign    <= bus.in_sign;
        s1_zero    <= bus.in_isZero;
        s1_inf     <= bus.in_isInf;
        s1_scale   <= bus.in_scale;
        s1_carry   <= carry;
        s1_frac    <= frac_inc;
        s1_inexact <= inexact;
        for (int unsigned l = 0; l < LANES; l++) begin
          lfsr[l] <= lfsrNext(lfsr[l]);
        end
      end
      if (s2_adv) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_sign     <= s1_sign;
          bus.out_isZero   <= s1_zero;
          bus.out_isInf    <= s1_inf;
          bus.out_scale    <= nxt_scale;
          bus.out_fraction <= nxt_frac;
          bus.out_inexact  <= s1_inexact;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_round_pipe.sv
// Directed + stochastic bench for posit_round_pipe (WIDTH=6, ES=0, one lane,
// two trailing bits, SEED=1). Expected beats are queued at accept time and
// compared as the DUT emits them.
module tb_posit_round_pipe;

  typedef struct packed {
    logic       sign;
    logic       zero;
    logic       inf;
    logic [3:0] scale;
    logic [2:0] frac;
    logic       inexact;
  } beat_t;

  logic clock;
  logic reset;

  posit_round_pipe_if #(.WIDTH(6), .ES(0), .LANES(1), .TRAILING_BITS(2)) bif ();

  posit_round_pipe #(
    .WIDTH         (6),
    .ES            (0),
    .LANES         (1),
    .TRAILING_BITS (2),
    .SEED          (16'h0001)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_vec;
  int          n_err;
  beat_t       q[$];
  logic [15:0] lfsr_model;
  logic        prev_stall;
  beat_t       held;
  logic        saw_in_ready_low;
  logic        stoch_phase;
  int          up_count;
  logic        done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic beat_t model(input logic [1:0] mode, input logic sign, input logic zero,
                                  input logic inf, input logic [3:0] scale, input logic [2:0] frac,
                                  input logic [1:0] tr, input logic st, input logic [15:0] lf);
    int    up;
    int    f;
    int    s;
    beat_t r;
    case (mode)
      2'd0:    up = (tr[1] && (tr[0] || st || frac[0])) ? 1 : 0;
      2'd1:    up = 0;
      2'd2:    up = (tr != 2'b00 || st) ? 1 : 0;
      default: up = ((int'({tr, st}) + int'(lf[2:0])) >= 8) ? 1 : 0;
    endcase
    if (zero || inf) up = 0;
    f = int'(frac) + up;
    s = int'($signed(scale));
    if (f == 8) begin
      f = 0;
      s = s + 1;
    end
    if (!zero && !inf && s > 4) begin
      s = 4;
      f = 0;
    end
    r.sign    = sign;
    r.zero    = zero;
    r.inf     = inf;
    r.scale   = 4'(s);
    r.frac    = 3'(f);
    r.inexact = !zero && !inf && (tr != 2'b00 || st);
    return r;
  endfunction

  function automatic beat_t cur_out();
    beat_t c;
    c.sign    = bif.out_sign[0];
    c.zero    = bif.out_isZero[0];
    c.inf     = bif.out_isInf[0];
    c.scale   = bif.out_scale;
    c.frac    = bif.out_fraction;
    c.inexact = bif.out_inexact[0];
    return c;
  endfunction

  // Output monitor: pops the scoreboard on each transfer and checks that a
  // stalled output holds its value.
  always @(negedge clock) begin
    beat_t c;
    beat_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      c = cur_out();
      if (prev_stall) begin
        chk("stall_valid", 32'(bif.out_valid), 32'd1);
        chk("stall_data", 32'(c), 32'(held));
      end
      if (bif.in_valid && !bif.in_ready) saw_in_ready_low = 1'b1;
      if (bif.out_valid && bif.out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL unexpected_output: observed %0h expected none", c);
        end else begin
          e = q.pop_front();
          chk("beat", 32'(c), 32'(e));
          if (stoch_phase && c.frac == 3'b001) up_count++;
        end
      end
      prev_stall = bif.out_valid && !bif.out_ready;
      held = c;
    end
  end

  task automatic send(input logic [1:0] mode, input logic sign, input logic zero, input logic inf,
                      input logic [3:0] scale, input logic [2:0] frac, input logic [1:0] tr,
                      input logic st);
    logic acc;
    acc = 1'b0;
    bif.in_mode     = mode;
    bif.in_sign     = sign;
    bif.in_isZero   = zero;
    bif.in_isInf    = inf;
    bif.in_scale    = scale;
    bif.in_fraction = frac;
    bif.in_trailing = tr;
    bif.in_sticky   = st;
    bif.in_valid    = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (bif.in_ready) begin
        acc = 1'b1;
        q.push_back(model(mode, sign, zero, inf, scale, frac, tr, st, lfsr_model));
        lfsr_model = lfsr_step(lfsr_model);
      end
      @(posedge clock);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1");
    end
    bif.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clock);
    repeat (2) @(posedge clock);
    #1;
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    lfsr_model = 16'h0001;
    prev_stall = 1'b0;
    saw_in_ready_low = 1'b0;
    stoch_phase = 1'b0;
    up_count = 0;
    done = 1'b0;
    reset = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_mode = 2'd0;
    bif.in_sign = '0;
    bif.in_isZero = '0;
    bif.in_isInf = '0;
    bif.in_scale = '0;
    bif.in_fraction = '0;
    bif.in_trailing = '0;
    bif.in_sticky = '0;
    bif.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_out_data", 32'(cur_out()), 32'd0);
    @(posedge clock);
    #1;

    // Directed rounding cases: mode, sign, zero, inf, scale, frac, trailing, sticky.
    send(2'd0, 0, 0, 0, 4'd0,  3'b011, 2'b10, 0);  // RNE up -> 100
    send(2'd0, 0, 0, 0, 4'd0,  3'b010, 2'b10, 0);  // tie to even stays
    send(2'd0, 0, 0, 0, 4'd1,  3'b111, 2'b11, 0);  // carry into scale 2
    send(2'd0, 1, 0, 0, 4'd4,  3'b111, 2'b11, 0);  // saturate at maxpos
    send(2'd0, 0, 0, 0, 4'd3,  3'b111, 2'b11, 0);  // carry lands on MAX_SCALE
    send(2'd0, 1, 0, 0, 4'hD,  3'b111, 2'b10, 1);  // negative scale carry
    send(2'd1, 0, 0, 0, 4'd0,  3'b010, 2'b00, 1);  // RTZ
    send(2'd2, 0, 0, 0, 4'd0,  3'b010, 2'b00, 1);  // RAZ
    send(2'd0, 0, 0, 0, 4'd0,  3'b010, 2'b00, 1);  // RNE below half
    send(2'd2, 0, 1, 0, 4'd2,  3'b101, 2'b11, 1);  // zero passes through
    send(2'd2, 1, 0, 1, 4'd5,  3'b111, 2'b11, 1);  // inf passes through
    send(2'd2, 0, 0, 0, 4'd1,  3'b110, 2'b00, 0);  // exact
    drain("directed_drain");

    // Backpressure: 8 beats with out_ready low for cycles 3..6.
    saw_in_ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(2'd1, 0, 0, 0, 4'(i % 4), 3'(i), 2'b01, 0);
      end
      begin
        repeat (3) begin @(posedge clock); #1; end
        bif.out_ready = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        bif.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_in_ready_low", 32'(saw_in_ready_low), 32'd1);

    // Stochastic: 1024 beats at exactly half an ulp with random stalls.
    stoch_phase = 1'b1;
    up_count = 0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1024; i++) send(2'd3, 0, 0, 0, 4'd0, 3'b000, 2'b10, 0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1;
          bif.out_ready = ($urandom_range(0, 3) != 0);
        end
        bif.out_ready = 1'b1;
      end
    join
    drain("stoch_drain");
    stoch_phase = 1'b0;
    chk("stoch_up_count_in_range", 32'(up_count >= 448 && up_count <= 576), 32'd1);

    // Reset with two beats in flight.
    bif.out_ready = 1'b0;
    send(2'd0, 0, 0, 0, 4'd0, 3'b011, 2'b10, 0);
    send(2'd2, 1, 0, 0, 4'd1, 3'b001, 2'b01, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_out_valid", 32'(bif.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bif.in_ready), 32'd1);
    q.delete();
    lfsr_model = 16'h0001;
    bif.out_ready = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 24; i++)
      send(2'd3, 1'($urandom_range(0, 1)), 0, 0, 4'($urandom_range(0, 4)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    drain("post_reset_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
